serial_ch_rx: RTL and testbench
===============================

// Module: serial_ch_rx
// PURPOSE
//   Receiver for one serial output channel (data_out_chN / data_vld_chN pair) of the
//   chaoslogic datapath. Sits directly downstream of output_stage, on the clk_out16x domain.
//   Deserialises the MSB-first gray-coded stream into DATA_W-bit words and decodes them
//   gray->binary. Buffers words in a small show-ahead FIFO with a valid/ready handshake.
//   Reports per-frame word count, fragment errors and overflow errors.
// PARAMETERS
//   DATA_W  16  word width in bits; also the serial bits per word
//   DEPTH   4   output FIFO depth in words; must be a power of 2, >= 2
//   CNT_W   8   width of the frame word counter; saturates at 2^CNT_W-1
// PORTS
//   clk_out16x   in   1       sole clock; all logic on its rising edge
//   rst          in   1       synchronous reset, active-high
//   ser_in       in   1       serial data bit (from data_out_chN)
//   ser_vld      in   1       bit-valid / frame envelope (from data_vld_chN)
//   word_ready   in   1       consumer accepts word_out this cycle
//   word_out     out  DATA_W  binary-decoded word at FIFO head
//   word_valid   out  1       FIFO non-empty; word_out is meaningful
//   frame_done   out  1       1-cycle pulse at the end of a frame
//   frame_words  out  CNT_W   complete words in the last frame; held until the next frame_done
//   frag_err     out  1       1-cycle pulse with frame_done when a frame ends mid-word
//   ovf_err      out  1       1-cycle pulse when a completed word is dropped because the FIFO is full
// BEHAVIOUR
//   Reset: FSM=IDLE; shift reg, bit_cnt, word_cnt and FIFO pointers cleared.
//     All outputs 0: word_out, word_valid, frame_done, frame_words, frag_err, ovf_err.
//   Reset has priority over every other event.
//     Reset mid-frame discards the partial word and the frame; no frag_err or frame_done is raised.
//   Shifting: sr <= {sr[DATA_W-2:0], ser_in}. The first bit sampled is the word MSB.
//   FSM IDLE:
//     ser_vld=0 -> stay.
//     ser_vld=1 -> shift ser_in, bit_cnt<=1, word_cnt<=0, go SHIFT.
//   FSM SHIFT:
//     ser_vld=1 -> shift ser_in, bit_cnt++.
//       On the DATA_W-th bit: g={sr[DATA_W-2:0],ser_in} is decoded and pushed into the FIFO
//       at that same edge; bit_cnt<=0; word_cnt++ (saturating).
//     ser_vld=0 -> go IDLE at that edge; next cycle:
//       frame_done=1, frame_words=word_cnt (0 if no word completed), frag_err=(bit_cnt!=0).
//       The partial word is discarded.
//   Back-to-back frames: one low cycle of ser_vld is sufficient to delimit them.
//     A bit arriving in the cycle IDLE is re-entered is accepted as bit 1 of the new frame.
//   Gray decode: b[DATA_W-1]=g[DATA_W-1]; b[i]=b[i+1]^g[i] (combinational, before the push).
//   FIFO: show-ahead.
//     word_valid=!empty; word_out=mem[rd_ptr].
//     Pop when word_valid && word_ready.
//     Latency: word_valid is high in the cycle after the edge that sampled the last bit of the word
//       (when the FIFO was empty).
//     Push and pop in the same cycle, FIFO not full -> both occur; count unchanged.
//     Push and pop in the same cycle, FIFO full -> both occur; no overflow.
//     Push with FIFO full and no pop -> word dropped, FIFO contents unchanged, ovf_err=1 next cycle.
//       The word is still counted in frame_words.
//     Pop when empty -> ignored.
//     Pointers are log2(DEPTH)+1 bits and wrap naturally.
//   word_out holds its value while word_valid=1 and word_ready=0.
// TESTING
//   1. Hold rst=1 for 3 cycles with random ser_in/ser_vld -> all outputs 0, word_valid=0.
//   2. ser_vld=1 for 16 bits of gray 16'hC000, then ser_vld=0 -> word_out=16'h8000 with
//      word_valid one cycle after bit 16; frame_done=1, frame_words=1, frag_err=0.
//   3. One 48-bit frame of gray FFFF,0003,0000 with word_ready=1 -> words AAAA,0002,0000 in order;
//      frame_words=3; no errors.
//   4. 20-bit frame (gray FFFF + 4 bits) -> one word AAAA; frame_done with frame_words=1 and frag_err=1.
//   5. word_ready=0, frame of DEPTH+1=5 words -> ovf_err pulses once; frame_words=5.
//      Then word_ready=1 -> exactly the first 4 words drain, in order.
//   6. rst=1 after 10 bits of a frame, then a clean 16-bit frame -> no frame_done or frag_err from the
//      aborted frame; the new frame yields one correct word with frame_words=1.

Source files
------------

// File: rtl/serial_ch_rx.sv
// Serial channel receiver: deserialises an MSB-first gray-coded bit stream into words,
// decodes them to binary and buffers them in a show-ahead FIFO with frame/error reporting.
module serial_ch_rx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_out16x,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_vld,
    input  logic              word_ready,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_words,
    output logic              frag_err,
    output logic              ovf_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_W + 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] sr_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  frame_words_q;
    logic              frame_done_q, frag_err_q, ovf_err_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

    logic              start, shift_en, last_bit, end_frame;
    logic [DATA_W-1:0] gray, bin;
    logic              empty, full, push, pop, push_ok;

    // State register
    always_ff @(posedge clk_out16x) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ser_vld)  state_d = StShift;
            StShift: if (!ser_vld) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM decoded controls
    always_comb begin
        start     = 1'b0;
        shift_en  = 1'b0;
        last_bit  = 1'b0;
        end_frame = 1'b0;
        unique case (state_q)
            StIdle: begin
                start    = ser_vld;
                shift_en = ser_vld;
            end
            StShift: begin
                shift_en  = ser_vld;
                last_bit  = ser_vld && (bit_cnt_q == BW'(DATA_W - 1));
                end_frame = !ser_vld;
            end
            default: ;
        endcase
    end

    // Each binary bit is the XOR of all gray bits at or above it.
    assign gray = {sr_q[DATA_W-2:0], ser_in};
    always_comb begin
        bin = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && word_ready;
    assign push    = last_bit;
    assign push_ok = push && (!full || pop);

    // Shift register, bit/word counters and frame status
    always_ff @(posedge clk_out16x) begin
        if (rst) begin
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            frame_words_q <= '0;
            frame_done_q  <= 1'b0;
            frag_err_q    <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            frame_done_q <= end_frame;
            frag_err_q   <= end_frame && (bit_cnt_q != '0);
            ovf_err_q    <= push && !push_ok;
            if (end_frame) begin
                frame_words_q <= word_cnt_q;
            end
            if (shift_en) begin
                sr_q <= gray;
            end
            if (start) begin
                bit_cnt_q  <= BW'(1);
                word_cnt_q <= '0;
            end else if (last_bit) begin
                bit_cnt_q <= '0;
                if (word_cnt_q != '1) begin
                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                end
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_out16x) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage is not reset; word_out is masked while the FIFO is empty.
    always_ff @(posedge clk_out16x) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= bin;
        end
    end

    assign word_valid  = !empty;
    assign word_out    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign frame_done  = frame_done_q;
    assign frame_words = frame_words_q;
    assign frag_err    = frag_err_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_serial_ch_rx.sv
// Scoreboard bench for serial_ch_rx: directed frames push expected words/frame reports,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_serial_ch_rx;

    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_in = 1'b0;
    logic ser_vld = 1'b0;
    logic word_ready = 1'b0;
    logic [DW-1:0] word_out;
    logic word_valid, frame_done, frag_err, ovf_err;
    logic [CW-1:0] frame_words;

    serial_ch_rx #(.DATA_W(DW), .DEPTH(4), .CNT_W(CW)) dut (
        .clk_out16x (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_vld    (ser_vld),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .frame_done (frame_done),
        .frame_words(frame_words),
        .frag_err   (frag_err),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int ovf_seen = 0;
    logic [DW-1:0] exp_words[$];
    logic [CW:0]   exp_frames[$];  // {frag_err, frame_words}

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) begin
                if (exp_words.size() == 0) unexpected("unexpected_word", word_out);
                else check("word", word_out, exp_words.pop_front());
            end
            if (frame_done) begin
                if (exp_frames.size() == 0) unexpected("unexpected_frame", {frag_err, frame_words});
                else check("frame{frag,words}", {frag_err, frame_words}, exp_frames.pop_front());
            end
            if (frag_err && !frame_done) unexpected("frag_without_done", frag_err);
            if (ovf_err) ovf_seen++;
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        ser_vld = 1'b1;
        ser_in  = b;
    endtask

    task automatic send_word(input logic [DW-1:0] g);
        for (int i = DW - 1; i >= 0; i--) send_bit(g[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ser_vld = 1'b0;
            ser_in  = 1'b0;
        end
    endtask

    initial begin
        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ser_in  = 1'($urandom);
            ser_vld = 1'($urandom);
        end
        @(posedge clk); #1;
        check("rst_outputs", {word_out, word_valid, frame_done, frame_words, frag_err, ovf_err}, 0);
        ser_vld = 1'b0;
        rst = 1'b0;
        idle(2);

        // 2: single word, latency
        word_ready = 1'b1;
        exp_words.push_back(16'h8000);
        exp_frames.push_back({1'b0, 8'd1});
        send_word(16'hC000);
        check("valid_before_last_edge", word_valid, 0);
        @(posedge clk); #1;
        ser_vld = 1'b0;
        check("valid_after_last_edge", word_valid, 1);
        check("word_out_after_last_edge", word_out, 16'h8000);
        idle(3);

        // 3: three words in one frame
        exp_words.push_back(16'hAAAA);
        exp_words.push_back(16'h0002);
        exp_words.push_back(16'h0000);
        exp_frames.push_back({1'b0, 8'd3});
        send_word(16'hFFFF);
        send_word(16'h0003);
        send_word(16'h0000);
        idle(4);

        // 4: fragment
        exp_words.push_back(16'hAAAA);
        exp_frames.push_back({1'b1, 8'd1});
        send_word(16'hFFFF);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        idle(4);
        check("no_ovf_yet", ovf_seen, 0);

        // 5: overflow with consumer stalled
        word_ready = 1'b0;
        exp_words.push_back(16'h0001);
        exp_words.push_back(16'h0003);
        exp_words.push_back(16'h0002);
        exp_words.push_back(16'h0007);
        exp_frames.push_back({1'b0, 8'd5});
        for (int w = 1; w <= 5; w++) send_word(16'(w));
        idle(4);
        check("ovf_pulses", ovf_seen, 1);
        check("frames_reported_t5", exp_frames.size(), 0);
        check("head_held_valid", word_valid, 1);
        check("head_held_word", word_out, 16'h0001);
        idle(3);
        check("head_still_held", word_out, 16'h0001);
        word_ready = 1'b1;
        idle(8);
        check("drained_valid", word_valid, 0);
        check("drained_queue", exp_words.size(), 0);

        // 6: reset mid-frame, then a clean frame
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        ser_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        check("no_valid_after_abort", word_valid, 0);
        exp_words.push_back(16'hFFFE);
        exp_frames.push_back({1'b0, 8'd1});
        send_word(16'h8001);
        idle(4);

        for (int i = 0; i < 50 && (exp_words.size() != 0 || exp_frames.size() != 0); i++) idle(1);
        check("final_words_pending", exp_words.size(), 0);
        check("final_frames_pending", exp_frames.size(), 0);
        check("final_ovf_total", ovf_seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
